fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It owns the PC, drives the instruction-memory read address, and assembles two-word (immediate) instructions. It also loads the reset and interrupt vectors and handles redirects from later stages. It drives the IF/ID pipeline register outputs that feed decode's instruction input and interrupt input.

Parameters:
PC_WIDTH, 16, width of PC and instruction-memory address
RESET_VEC_ADDR, 0, memory word holding the reset PC
INT_VEC_ADDR, 1, memory word holding the interrupt handler PC

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_stall  in  1  hazard stall from downstream; freezes stage
i_redirect  in  1  taken branch / return; load i_redirect_pc
i_redirect_pc  in  PC_WIDTH  redirect target
i_interrupt  in  1  external interrupt request (pulse or level)
i_imem_data  in  16  instruction-memory read data (combinational read of o_imem_addr)
o_imem_addr  out  PC_WIDTH  instruction-memory read address
o_instr  out  16  registered instruction word to decode
o_imm_value  out  16  registered immediate (second word), 0 for one-word instrs
o_pc  out  PC_WIDTH  registered address of o_instr's first word
o_pc_next  out  PC_WIDTH  registered address after the full instruction (return address)
o_valid  out  1  o_instr is a real instruction or interrupt token
o_interrupt  out  1  registered interrupt token to decode

Behaviour:
- ISA rule: an instruction word with bit 0 = 1 is two-word; the next memory word is its immediate.
- States: S_BOOT, S_RUN, S_IMM, S_INT.
- Reset (sync): state <= S_BOOT, PC <= 0, int_pending <= 0. All outputs are 0, including o_valid and o_interrupt. Reset mid-operation discards any held first word.
- o_imem_addr is combinational: RESET_VEC_ADDR in S_BOOT, INT_VEC_ADDR in S_INT, PC otherwise.
- S_BOOT: PC <= i_imem_data; o_valid <= 0; go to S_RUN. Stall and redirect are ignored.
- S_RUN, one-word instruction (bit0 = 0):
  - o_instr <= data, o_imm_value <= 0, o_pc <= PC, o_pc_next <= PC+1, o_valid <= 1.
  - PC <= PC+1.
- S_RUN, two-word instruction (bit0 = 1):
  - Hold the first word and its PC internally; PC <= PC+1; o_valid <= 0; go to S_IMM.
- S_IMM:
  - o_instr <= held word, o_imm_value <= data, o_pc <= held PC, o_pc_next <= PC+1, o_valid <= 1.
  - PC <= PC+1; go to S_RUN.
- Interrupt latching: int_pending is set on any cycle with i_interrupt = 1. It is cleared when the interrupt token is issued.
- Interrupt issue: taken only in S_RUN at an instruction boundary, never inside S_IMM. The token replaces the fetch:
  - o_instr <= 0, o_valid <= 1, o_interrupt <= 1, o_pc <= PC, o_pc_next <= PC (return address). PC is not incremented.
  - Go to S_INT.
- o_interrupt is a 1-cycle token; it is 0 on every other issue.
- S_INT: PC <= i_imem_data; o_valid <= 0; go to S_RUN. Stall and redirect are ignored.
- Priority, in S_RUN/S_IMM: reset > redirect > stall > interrupt > normal fetch.
- Redirect (S_RUN or S_IMM): PC <= i_redirect_pc; o_valid <= 0; o_interrupt <= 0; state <= S_RUN. Any held first word is dropped. Redirect overrides a simultaneous stall. int_pending is kept.
- Stall without redirect: PC, state, held word and all outputs hold their values. int_pending may still be set.
- Arithmetic: PC+1 is modulo 2^PC_WIDTH, so 0xFFFF wraps to 0x0000.
- Latency: the memory word addressed in cycle n appears on the outputs after edge n.

Test Plan:
- Boot: mem[0]=0x0010, mem[0x10]=0x2400. Release reset.
  -> Cycle 1: o_imem_addr = 0, o_valid = 0.
  -> Cycle 2: o_imem_addr = 0x10.
  -> After the next edge: o_instr = 0x2400, o_pc = 0x10, o_pc_next = 0x11, o_valid = 1.
- Two-word: mem[0x10]=0x4801, mem[0x11]=0xBEEF.
  -> One bubble (o_valid = 0), then o_instr = 0x4801, o_imm_value = 0xBEEF, o_pc = 0x10, o_pc_next = 0x12.
- Interrupt during S_IMM: pulse i_interrupt while the first word of a two-word instr is held; mem[1]=0x0200.
  -> The full instruction issues first.
  -> Then a token: o_interrupt = 1, o_pc_next = 0x12.
  -> One bubble, then fetch from 0x200.
- Stall: assert i_stall for 3 cycles mid-stream.
  -> o_instr, o_pc and o_valid are frozen for 3 cycles; no PC skipped or repeated afterwards.
- Redirect in S_IMM with simultaneous stall: i_redirect_pc = 0x0300.
  -> Held word is dropped, o_valid = 0, next fetch address is 0x300.
- Wrap: PC = 0xFFFF holding a one-word instr.
  -> o_pc_next = 0x0000 and the next fetch address is 0x0000.
- Reset asserted in S_IMM or S_INT.
  -> All outputs are 0 on the next edge and the stage restarts in S_BOOT.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, loads reset/interrupt vectors, assembles
// two-word instructions and drives the IF/ID register feeding decode.
module fetch_stage #(
  parameter int unsigned PC_WIDTH       = 16,
  parameter int unsigned RESET_VEC_ADDR = 0,
  parameter int unsigned INT_VEC_ADDR   = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic                i_redirect,
  input  logic [PC_WIDTH-1:0] i_redirect_pc,
  input  logic                i_interrupt,
  input  logic [15:0]         i_imem_data,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  output logic [15:0]         o_instr,
  output logic [15:0]         o_imm_value,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_pc_next,
  output logic                o_valid,
  output logic                o_interrupt
);

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_IMM, S_INT} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic                int_pending_q, int_pending_d;
  logic [WORD_W-1:0]   held_word_q, held_word_d;
  logic [PC_WIDTH-1:0] held_pc_q, held_pc_d;

  logic [WORD_W-1:0]   instr_d, imm_value_d;
  logic [PC_WIDTH-1:0] out_pc_d, out_pc_next_d;
  logic                valid_d, interrupt_d;

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // State, PC and IF/ID output register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_BOOT;
      pc_q          <= '0;
      int_pending_q <= 1'b0;
      held_word_q   <= '0;
      held_pc_q     <= '0;
      o_instr       <= '0;
      o_imm_value   <= '0;
      o_pc          <= '0;
      o_pc_next     <= '0;
      o_valid       <= 1'b0;
      o_interrupt   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      int_pending_q <= int_pending_d;
      held_word_q   <= held_word_d;
      held_pc_q     <= held_pc_d;
      o_instr       <= instr_d;
      o_imm_value   <= imm_value_d;
      o_pc          <= out_pc_d;
      o_pc_next     <= out_pc_next_d;
      o_valid       <= valid_d;
      o_interrupt   <= interrupt_d;
    end
  end

  // Next-state, fetch address and next output values
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    int_pending_d = int_pending_q | i_interrupt;
    held_word_d   = held_word_q;
    held_pc_d     = held_pc_q;
    instr_d       = o_instr;
    imm_value_d   = o_imm_value;
    out_pc_d      = o_pc;
    out_pc_next_d = o_pc_next;
    valid_d       = o_valid;
    interrupt_d   = o_interrupt;
    o_imem_addr   = pc_q;

    case (state_q)
      S_BOOT, S_INT: begin
        // Vector fetch: the addressed word is the new PC
        o_imem_addr = (state_q == S_BOOT) ? PC_WIDTH'(RESET_VEC_ADDR)
                                          : PC_WIDTH'(INT_VEC_ADDR);
        pc_d        = PC_WIDTH'(i_imem_data);
        valid_d     = 1'b0;
        interrupt_d = 1'b0;
        state_d     = S_RUN;
      end

      S_RUN, S_IMM: begin
        if (i_redirect) begin
          pc_d        = i_redirect_pc;
          valid_d     = 1'b0;
          interrupt_d = 1'b0;
          state_d     = S_RUN;
        end else if (!i_stall) begin
          if (state_q == S_IMM) begin
            instr_d       = held_word_q;
            imm_value_d   = i_imem_data;
            out_pc_d      = held_pc_q;
            out_pc_next_d = pc_inc;
            valid_d       = 1'b1;
            interrupt_d   = 1'b0;
            pc_d          = pc_inc;
            state_d       = S_RUN;
          end else if (int_pending_q) begin
            // Interrupt token replaces this fetch; PC is the return address
            instr_d       = '0;
            imm_value_d   = '0;
            out_pc_d      = pc_q;
            out_pc_next_d = pc_q;
            valid_d       = 1'b1;
            interrupt_d   = 1'b1;
            int_pending_d = i_interrupt;
            state_d       = S_INT;
          end else if (i_imem_data[0]) begin
            held_word_d = i_imem_data;
            held_pc_d   = pc_q;
            valid_d     = 1'b0;
            interrupt_d = 1'b0;
            pc_d        = pc_inc;
            state_d     = S_IMM;
          end else begin
            instr_d       = i_imem_data;
            imm_value_d   = '0;
            out_pc_d      = pc_q;
            out_pc_next_d = pc_inc;
            valid_d       = 1'b1;
            interrupt_d   = 1'b0;
            pc_d          = pc_inc;
          end
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then random stimulus against a behavioural fetch model.
module tb_fetch_stage;

  localparam int unsigned PW        = 16;
  localparam int unsigned MEM_WORDS = 65536;
  localparam int unsigned RAND_CYC  = 4000;

  localparam int P_BOOT   = 0;
  localparam int P_SEQ    = 1;
  localparam int P_SECOND = 2;
  localparam int P_VEC    = 3;

  logic          clk = 1'b0;
  logic          reset, stall, redirect, interrupt;
  logic [PW-1:0] redirect_pc;
  logic [15:0]   imem_data;
  logic [PW-1:0] imem_addr, pc, pc_next;
  logic [15:0]   instr, imm_value;
  logic          valid, intr_out;

  logic [15:0]   mem [MEM_WORDS];
  logic [PW-1:0] addr_seen;

  // Behavioural model state
  int            m_phase;
  logic [15:0]   m_pc, m_first, m_first_pc;
  logic          m_pend;
  logic [15:0]   e_instr, e_imm, e_pc, e_pcn;
  logic          e_valid, e_intr, e_zero;

  int n_pass  = 0;
  int n_total = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage #(.PC_WIDTH(PW), .RESET_VEC_ADDR(0), .INT_VEC_ADDR(1)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_interrupt  (interrupt),
    .i_imem_data  (imem_data),
    .o_imem_addr  (imem_addr),
    .o_instr      (instr),
    .o_imm_value  (imm_value),
    .o_pc         (pc),
    .o_pc_next    (pc_next),
    .o_valid      (valid),
    .o_interrupt  (intr_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] m_fetch_addr();
    if (m_phase == P_BOOT) return 16'h0000;
    if (m_phase == P_VEC)  return 16'h0001;
    return m_pc;
  endfunction

  // What the stage must present after one rising edge, given this cycle's inputs
  task automatic model_step();
    logic [15:0] d;
    logic        took;
    d    = mem[m_fetch_addr()];
    took = 1'b0;
    if (reset) begin
      m_phase = P_BOOT; m_pc = '0; m_pend = 1'b0;
      e_instr = '0; e_imm = '0; e_pc = '0; e_pcn = '0;
      e_valid = 1'b0; e_intr = 1'b0; e_zero = 1'b1;
      return;
    end
    e_zero = 1'b0;
    if (m_phase == P_BOOT || m_phase == P_VEC) begin
      m_pc = d; e_valid = 1'b0; e_intr = 1'b0; m_phase = P_SEQ;
    end else if (redirect) begin
      m_pc = redirect_pc; e_valid = 1'b0; e_intr = 1'b0; m_phase = P_SEQ;
    end else if (!stall) begin
      if (m_phase == P_SECOND) begin
        e_instr = m_first; e_imm = d; e_pc = m_first_pc; e_pcn = m_pc + 16'd1;
        e_valid = 1'b1; e_intr = 1'b0; m_pc = m_pc + 16'd1; m_phase = P_SEQ;
      end else if (m_pend) begin
        e_instr = '0; e_imm = '0; e_pc = m_pc; e_pcn = m_pc;
        e_valid = 1'b1; e_intr = 1'b1; took = 1'b1; m_phase = P_VEC;
      end else if (d[0]) begin
        m_first = d; m_first_pc = m_pc; m_pc = m_pc + 16'd1;
        e_valid = 1'b0; e_intr = 1'b0; m_phase = P_SECOND;
      end else begin
        e_instr = d; e_imm = '0; e_pc = m_pc; e_pcn = m_pc + 16'd1;
        e_valid = 1'b1; e_intr = 1'b0; m_pc = m_pc + 16'd1;
      end
    end
    m_pend = (m_pend && !took) || interrupt;
  endtask

  task automatic compare_outputs();
    chk("valid", 32'(valid), 32'(e_valid));
    chk("interrupt", 32'(intr_out), 32'(e_intr));
    if (e_valid || e_zero) begin
      chk("instr", 32'(instr), 32'(e_instr));
      chk("imm_value", 32'(imm_value), 32'(e_imm));
      chk("pc", 32'(pc), 32'(e_pc));
      chk("pc_next", 32'(pc_next), 32'(e_pcn));
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic rd,
                      input logic [15:0] rp, input logic it);
    @(negedge clk);
    reset = r; stall = s; redirect = rd; redirect_pc = rp; interrupt = it;
    #1;
    addr_seen = imem_addr;
    chk("imem_addr", 32'(imem_addr), 32'(m_fetch_addr()));
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic run(); tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b0); endtask

  task automatic chk_out(input string name, input logic [15:0] ei, input logic [15:0] eimm,
                         input logic [15:0] ep, input logic [15:0] epn, input logic ev);
    chk({name, "_instr"}, 32'(instr), 32'(ei));
    chk({name, "_imm"}, 32'(imm_value), 32'(eimm));
    chk({name, "_pc"}, 32'(pc), 32'(ep));
    chk({name, "_pc_next"}, 32'(pc_next), 32'(epn));
    chk({name, "_valid"}, 32'(valid), 32'(ev));
  endtask

  initial begin
    logic [15:0] rp;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; interrupt = 1'b0;
    m_phase = P_BOOT; m_pc = '0; m_pend = 1'b0; m_first = '0; m_first_pc = '0;
    e_instr = '0; e_imm = '0; e_pc = '0; e_pcn = '0;
    e_valid = 1'b0; e_intr = 1'b0; e_zero = 1'b1;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0010; mem[16'h0001] = 16'h0200;
    mem[16'h0010] = 16'h2400; mem[16'h0011] = 16'h4801; mem[16'h0012] = 16'hBEEF;
    mem[16'h0013] = 16'h5003; mem[16'h0014] = 16'h1234;
    mem[16'h0200] = 16'h0600; mem[16'h0201] = 16'h0700; mem[16'h0202] = 16'h0800;
    mem[16'h0203] = 16'h0901; mem[16'h0300] = 16'h0A00; mem[16'hFFFF] = 16'h0B00;

    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk_out("reset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    // Boot through the reset vector
    run(); chk("boot_addr", 32'(addr_seen), 32'h0000); chk("boot_valid", 32'(valid), 32'h0);
    run(); chk("first_addr", 32'(addr_seen), 32'h0010);
    chk_out("first", 16'h2400, 16'h0, 16'h0010, 16'h0011, 1'b1);

    // Two-word instruction: bubble then full instruction
    run(); chk("bubble_valid", 32'(valid), 32'h0);
    run(); chk_out("two_word", 16'h4801, 16'hBEEF, 16'h0011, 16'h0013, 1'b1);

    // Interrupt pulsed while the first word is held
    run(); chk("imm_bubble", 32'(valid), 32'h0);
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk_out("int_imm", 16'h5003, 16'h1234, 16'h0013, 16'h0015, 1'b1);
    run(); chk("token", 32'(intr_out), 32'h1);
    chk_out("token", 16'h0, 16'h0, 16'h0015, 16'h0015, 1'b1);
    run(); chk("vec_addr", 32'(addr_seen), 32'h0001); chk("vec_intr", 32'(intr_out), 32'h0);
    run(); chk("handler_addr", 32'(addr_seen), 32'h0200);
    chk_out("handler", 16'h0600, 16'h0, 16'h0200, 16'h0201, 1'b1);

    // Three-cycle stall mid-stream
    run();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk_out("stall", 16'h0700, 16'h0, 16'h0201, 16'h0202, 1'b1);
    end
    run(); chk("post_stall_addr", 32'(addr_seen), 32'h0202);
    chk_out("post_stall", 16'h0800, 16'h0, 16'h0202, 16'h0203, 1'b1);

    // Redirect with simultaneous stall while a first word is held
    run();
    tick(1'b0, 1'b1, 1'b1, 16'h0300, 1'b0); chk("redir_valid", 32'(valid), 32'h0);
    run(); chk("redir_addr", 32'(addr_seen), 32'h0300);
    chk_out("redir", 16'h0A00, 16'h0, 16'h0300, 16'h0301, 1'b1);

    // PC wrap at the top of memory
    tick(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    run(); chk_out("wrap", 16'h0B00, 16'h0, 16'hFFFF, 16'h0000, 1'b1);
    run(); chk("wrap_addr", 32'(addr_seen), 32'h0000);

    // Reset while a first word is held
    tick(1'b0, 1'b0, 1'b1, 16'h0203, 1'b0);
    run();
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk_out("rst_imm", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    run(); chk("rst_imm_boot", 32'(addr_seen), 32'h0000);

    // Reset while fetching the interrupt vector
    tick(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    run(); chk("token2", 32'(intr_out), 32'h1);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk_out("rst_int", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("rst_int_intr", 32'(intr_out), 32'h0);
    run(); chk("rst_int_boot", 32'(addr_seen), 32'h0000);

    // Random program, random control traffic
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'($urandom);
    for (int c = 0; c < int'(RAND_CYC); c++) begin
      rp = ($urandom_range(0, 4) == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 1)))
                                       : 16'($urandom);
      tick(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 15),
           1'($urandom_range(0, 99) < 6), rp, 1'($urandom_range(0, 99) < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
